// File: rtl/mips_dunit_pkg.sv
// mips_dunit_pkg: shared state encoding and constants for the MIPS debug unit
package mips_dunit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } load_state_e;

   localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;
   localparam int          NB_WIDTH_DEF   = 9;

   function automatic int max_words(input int nb_width);
      return (1 << nb_width) / 4;
   endfunction

   localparam int MAX_WORDS = max_words(NB_WIDTH_DEF);

endpackage

// File: rtl/byte_packer.sv
// byte_packer: shifts UART bytes big-endian into a word and flags the completing byte
module byte_packer #(
   parameter int NB_REG  = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_clr,
   input  logic               i_en,
   input  logic [NB_BYTE-1:0] i_data,
   input  logic               i_valid,
   output logic [NB_REG-1:0]  o_word,
   output logic               o_word_valid
);
   localparam int NB_IDX = $clog2(NB_REG / NB_BYTE);

   // the newest byte is combined combinationally, so only the older bytes are stored
   logic [NB_REG-NB_BYTE-1:0] shift_q;
   logic [NB_IDX-1:0]         idx_q;
   logic                      take;

   assign take         = i_en && i_valid;
   assign o_word       = {shift_q, i_data};
   assign o_word_valid = take && (idx_q == '1);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else if (i_clr) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else if (take) begin
         shift_q <= {shift_q[NB_REG-2*NB_BYTE-1:0], i_data};
         idx_q   <= idx_q + NB_IDX'(1);
      end
   end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: packs debug-UART bytes into instructions and writes them to instruction memory
module instr_loader import mips_dunit_pkg::*; #(
   parameter int                NB_REG     = 32,
   parameter int                NB_BYTE    = 8,
   parameter int                NB_WIDTH   = NB_WIDTH_DEF,
   parameter logic [NB_REG-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [NB_BYTE-1:0]  i_rx_data,
   input  logic                i_rx_valid,
   output logic                o_w_mem,
   output logic [NB_REG-1:0]   o_inst,
   output logic [NB_REG-1:0]   o_addr_inst,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_overflow,
   output logic [NB_WIDTH-2:0] o_word_count
);
   localparam int              NB_CNT  = NB_WIDTH - 1;
   localparam logic [NB_CNT-1:0] MAX_CNT = NB_CNT'(max_words(NB_WIDTH));

   load_state_e         state_q;
   logic [NB_WIDTH-1:0] addr_q;
   logic [NB_CNT-1:0]   cnt_q, cnt_d;
   logic [NB_REG-1:0]   inst_q, word;
   logic                word_valid, w_mem_q, busy_q, done_q, ovf_q;
   logic                pk_en, pk_clr;

   // a byte landing in WRITE is kept as byte 0 of the next word
   assign pk_en  = (state_q == RECV) || (state_q == WRITE);
   assign pk_clr = (state_q == IDLE) && i_start;
   assign cnt_d  = cnt_q + NB_CNT'(1);

   byte_packer #(.NB_REG(NB_REG), .NB_BYTE(NB_BYTE)) u_packer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clr        (pk_clr),
      .i_en         (pk_en),
      .i_data       (i_rx_data),
      .i_valid      (i_rx_valid),
      .o_word       (word),
      .o_word_valid (word_valid)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         inst_q  <= '0;
         w_mem_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         w_mem_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: if (i_start) begin
               state_q <= RECV;
               busy_q  <= 1'b1;
               addr_q  <= '0;
               cnt_q   <= '0;
               ovf_q   <= 1'b0;
            end
            RECV: if (word_valid) begin
               state_q <= WRITE;
               inst_q  <= word;
               w_mem_q <= 1'b1;
            end
            WRITE: begin
               addr_q <= addr_q + NB_WIDTH'(4);
               cnt_q  <= cnt_d;
               if (inst_q == HALT_INSTR || cnt_d == MAX_CNT) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  ovf_q   <= inst_q != HALT_INSTR;
               end else begin
                  state_q <= RECV;
               end
            end
            DONE: state_q <= IDLE;
         endcase
      end
   end

   assign o_w_mem      = w_mem_q;
   assign o_inst       = inst_q;
   assign o_addr_inst  = {{(NB_REG-NB_WIDTH){1'b0}}, addr_q};
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_overflow   = ovf_q;
   assign o_word_count = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader; expected writes and done events are queued by stimulus
module tb_instr_loader;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   typedef struct packed {
      logic [7:0] c;
      logic       o;
   } dn_t;

   logic        clk = 1'b0;
   logic        i_reset, i_start, i_rx_valid;
   logic [7:0]  i_rx_data;
   logic        o_w_mem, o_busy, o_done, o_overflow;
   logic [31:0] o_inst, o_addr_inst;
   logic [7:0]  o_word_count;

   int  total = 0;
   int  bad = 0;
   int  done_cnt = 0;
   logic prev_w = 1'b0;
   wr_t wq[$];
   dn_t dq[$];
   wr_t we;
   dn_t de;

   instr_loader dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_rx_data    (i_rx_data),
      .i_rx_valid   (i_rx_valid),
      .o_w_mem      (o_w_mem),
      .o_inst       (o_inst),
      .o_addr_inst  (o_addr_inst),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_overflow   (o_overflow),
      .o_word_count (o_word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: pops the scoreboard whenever the DUT strobes a write or a done
   always @(negedge clk) begin
      if (i_reset && o_w_mem) begin
         if (wq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %h inst %h expected no write", o_addr_inst, o_inst);
         end else begin
            we = wq.pop_front();
            chk("wr_addr", o_addr_inst, we.a);
            chk("wr_inst", o_inst, we.d);
         end
      end
      if (i_reset && o_done) begin
         done_cnt++;
         if (dq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done expected none");
         end else begin
            de = dq.pop_front();
            chk("done_count", {24'b0, o_word_count}, {24'b0, de.c});
            chk("done_overflow", {31'b0, o_overflow}, {31'b0, de.o});
            chk("done_busy_low", {31'b0, o_busy}, 32'd0);
            chk("done_after_write", {31'b0, prev_w}, 32'd1);
         end
      end
      prev_w = o_w_mem;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic put_byte(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
   endtask

   task automatic put_word(input logic [31:0] w, input bit gap);
      for (int i = 3; i >= 0; i--) begin
         put_byte(w[i*8 +: 8]);
         if (gap) tick();
      end
   endtask

   task automatic pulse_start;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic wait_done;
      int n0 = done_cnt;
      int k = 0;
      while (done_cnt == n0 && k < 2000) begin
         tick();
         k++;
      end
      total++;
      if (done_cnt == n0) begin
         bad++;
         $display("FAIL done_timeout: got no done expected done within 2000 cycles");
      end
      repeat (2) tick();
   endtask

   task automatic chk_reset_state;
      chk("rst_w_mem", {31'b0, o_w_mem}, 32'd0);
      chk("rst_inst", o_inst, 32'd0);
      chk("rst_addr", o_addr_inst, 32'd0);
      chk("rst_busy", {31'b0, o_busy}, 32'd0);
      chk("rst_done", {31'b0, o_done}, 32'd0);
      chk("rst_overflow", {31'b0, o_overflow}, 32'd0);
      chk("rst_count", {24'b0, o_word_count}, 32'd0);
   endtask

   initial begin
      i_reset = 1'b0; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
      repeat (2) tick();
      chk_reset_state();
      i_reset = 1'b1;
      tick();

      // basic program: one instruction then halt
      wq.push_back('{a: 32'd0, d: 32'h2001_0005});
      wq.push_back('{a: 32'd4, d: 32'hFFFF_FFFF});
      dq.push_back('{c: 8'd2, o: 1'b0});
      pulse_start();
      chk("busy_after_start", {31'b0, o_busy}, 32'd1);
      put_word(32'h2001_0005, 1'b1);
      put_word(32'hFFFF_FFFF, 1'b0);
      wait_done();

      // bytes while idle are ignored
      put_word(32'h1122_3344, 1'b0);
      repeat (5) tick();
      chk("idle_busy", {31'b0, o_busy}, 32'd0);
      chk("idle_count", {24'b0, o_word_count}, 32'd2);
      wq.push_back('{a: 32'd0, d: 32'hFFFF_FFFF});
      dq.push_back('{c: 8'd1, o: 1'b0});
      pulse_start();
      put_word(32'hFFFF_FFFF, 1'b1);
      wait_done();

      // memory fill without halt
      for (int i = 0; i < 128; i++) wq.push_back('{a: 32'(i * 4), d: 32'h0000_0001});
      dq.push_back('{c: 8'd128, o: 1'b1});
      pulse_start();
      for (int i = 0; i < 128; i++) put_word(32'h0000_0001, 1'b0);
      wait_done();
      chk("ovf_sticky", {31'b0, o_overflow}, 32'd1);
      chk("ovf_count", {24'b0, o_word_count}, 32'd128);
      wq.push_back('{a: 32'd0, d: 32'hFFFF_FFFF});
      dq.push_back('{c: 8'd1, o: 1'b0});
      pulse_start();
      chk("ovf_cleared", {31'b0, o_overflow}, 32'd0);
      chk("count_cleared", {24'b0, o_word_count}, 32'd0);
      put_word(32'hFFFF_FFFF, 1'b0);
      wait_done();

      // reset discards a partial word
      pulse_start();
      put_byte(8'hAB);
      put_byte(8'hCD);
      i_reset = 1'b0;
      #1;
      chk_reset_state();
      tick();
      i_reset = 1'b1;
      tick();
      wq.push_back('{a: 32'd0, d: 32'hFFFF_FFFF});
      dq.push_back('{c: 8'd1, o: 1'b0});
      pulse_start();
      put_word(32'hFFFF_FFFF, 1'b0);
      wait_done();

      // eight back-to-back bytes, fifth lands in the WRITE cycle
      wq.push_back('{a: 32'd0, d: 32'h1234_5678});
      wq.push_back('{a: 32'd4, d: 32'hFFFF_FFFF});
      dq.push_back('{c: 8'd2, o: 1'b0});
      pulse_start();
      put_word(32'h1234_5678, 1'b0);
      put_word(32'hFFFF_FFFF, 1'b0);
      wait_done();

      // start pulses during a load are ignored
      wq.push_back('{a: 32'd0, d: 32'hAABB_CCDD});
      wq.push_back('{a: 32'd4, d: 32'h0102_0304});
      wq.push_back('{a: 32'd8, d: 32'hFFFF_FFFF});
      dq.push_back('{c: 8'd3, o: 1'b0});
      pulse_start();
      put_byte(8'hAA);
      put_byte(8'hBB);
      pulse_start();
      i_start = 1'b1;
      put_byte(8'hCC);
      i_start = 1'b0;
      put_byte(8'hDD);
      put_word(32'h0102_0304, 1'b1);
      pulse_start();
      put_word(32'hFFFF_FFFF, 1'b1);
      wait_done();

      chk("writes_pending", 32'(wq.size()), 32'd0);
      chk("dones_pending", 32'(dq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
